// File: rtl/video_src_gen_if.sv
// Video stream bus between a pixel source and its consumer: one pixel per clock,
// active-high syncs, data enable only during active pixels.
interface video_src_gen_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] do_o;
    logic                  de_o;
    logic                  hs_o;
    logic                  vs_o;

    modport master (output do_o, de_o, hs_o, vs_o);
    modport slave  (input  do_o, de_o, hs_o, vs_o);
endinterface

// File: rtl/video_src_gen.sv
// Frame-timing master and test-pattern source; outputs registered one clock after the counters.
// Timing/pattern inputs are shadowed at every frame start; a frame in progress always completes.
module video_src_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16,
    parameter int CHECK_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [CNT_WIDTH-1:0]  h_sync,
    input  logic [CNT_WIDTH-1:0]  h_bp,
    input  logic [CNT_WIDTH-1:0]  h_act,
    input  logic [CNT_WIDTH-1:0]  h_fp,
    input  logic [CNT_WIDTH-1:0]  v_sync,
    input  logic [CNT_WIDTH-1:0]  v_bp,
    input  logic [CNT_WIDTH-1:0]  v_act,
    input  logic [CNT_WIDTH-1:0]  v_fp,
    input  logic [1:0]            pattern,
    input  logic [DATA_WIDTH-1:0] pattern_val,
    video_src_gen_if.master       vid,
    output logic [15:0]           frame_cnt_o,
    output logic                  busy_o
);
    localparam int W = CNT_WIDTH + 2;

    typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;

    state_t                state, state_nxt;
    logic                  load;
    logic [W-1:0]          h_cnt, v_cnt;
    logic [W-1:0]          hs_end, hde_beg, hde_end, h_tot;
    logic [W-1:0]          vs_end, vde_beg, vde_end, v_tot;
    logic [1:0]            pat;
    logic [DATA_WIDTH-1:0] pval;
    logic                  line_end, frame_end, de_nxt, chk_bit;
    logic [DATA_WIDTH-1:0] x_pix, y_pix, pix_nxt;

    // Region edges are kept as absolute counter positions so each compare is a single bound.
    assign x_pix   = DATA_WIDTH'(h_cnt - hde_beg);
    assign y_pix   = DATA_WIDTH'(v_cnt - vde_beg);
    assign chk_bit = 1'((h_cnt - hde_beg) >> CHECK_LOG2) ^ 1'((v_cnt - vde_beg) >> CHECK_LOG2);
    assign busy_o  = (state != IDLE);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        line_end  = (h_cnt == h_tot - W'(1));
        frame_end = line_end && (v_cnt == v_tot - W'(1));
        de_nxt    = (h_cnt >= hde_beg) && (h_cnt < hde_end) &&
                    (v_cnt >= vde_beg) && (v_cnt < vde_end);
        case (pat)
            2'd0:    pix_nxt = x_pix;
            2'd1:    pix_nxt = y_pix;
            2'd2:    pix_nxt = chk_bit ? '1 : '0;
            default: pix_nxt = pval;
        endcase
        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                end
            end
            RUN, LAST: begin
                // At frame end the current en decides between a gapless restart and idling.
                if (frame_end) begin
                    if (en) begin
                        state_nxt = RUN;
                        load      = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    state_nxt = en ? RUN : LAST;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            h_cnt       <= '0;
            v_cnt       <= '0;
            hs_end      <= '0;
            hde_beg     <= '0;
            hde_end     <= '0;
            h_tot       <= '0;
            vs_end      <= '0;
            vde_beg     <= '0;
            vde_end     <= '0;
            v_tot       <= '0;
            pat         <= '0;
            pval        <= '0;
            frame_cnt_o <= '0;
            vid.do_o    <= '0;
            vid.de_o    <= 1'b0;
            vid.hs_o    <= 1'b0;
            vid.vs_o    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                hs_end  <= W'(h_sync);
                hde_beg <= W'(h_sync) + W'(h_bp);
                hde_end <= W'(h_sync) + W'(h_bp) + W'(h_act);
                h_tot   <= W'(h_sync) + W'(h_bp) + W'(h_act) + W'(h_fp);
                vs_end  <= W'(v_sync);
                vde_beg <= W'(v_sync) + W'(v_bp);
                vde_end <= W'(v_sync) + W'(v_bp) + W'(v_act);
                v_tot   <= W'(v_sync) + W'(v_bp) + W'(v_act) + W'(v_fp);
                pat     <= pattern;
                pval    <= pattern_val;
            end
            if (state == IDLE || frame_end) begin
                h_cnt <= '0;
                v_cnt <= '0;
            end else if (line_end) begin
                h_cnt <= '0;
                v_cnt <= v_cnt + W'(1);
            end else begin
                h_cnt <= h_cnt + W'(1);
            end
            if (state != IDLE && frame_end)
                frame_cnt_o <= frame_cnt_o + 16'd1;
            if (state == IDLE) begin
                vid.do_o <= '0;
                vid.de_o <= 1'b0;
                vid.hs_o <= 1'b0;
                vid.vs_o <= 1'b0;
            end else begin
                vid.hs_o <= (h_cnt < hs_end);
                vid.vs_o <= (v_cnt < vs_end);
                vid.de_o <= de_nxt;
                vid.do_o <= de_nxt ? pix_nxt : '0;
            end
        end
    end
endmodule

// File: tb/tb_video_src_gen.sv
// Bench for video_src_gen: per-configuration frame runs with a pixel scoreboard, plus
// hand-written continuation, shadowing and mid-frame reset sequences.
module tb_video_src_gen;
    logic        clk = 1'b0;
    logic        rst, en;
    logic [15:0] h_sync, h_bp, h_act, h_fp, v_sync, v_bp, v_act, v_fp;
    logic [1:0]  pattern;
    logic [7:0]  pattern_val;
    logic [15:0] frame_cnt_o;
    logic        busy_o;

    video_src_gen_if #(.DATA_WIDTH(8)) vid();

    video_src_gen #(.DATA_WIDTH(8), .CNT_WIDTH(16), .CHECK_LOG2(1)) dut (
        .clk(clk), .rst(rst), .en(en),
        .h_sync(h_sync), .h_bp(h_bp), .h_act(h_act), .h_fp(h_fp),
        .v_sync(v_sync), .v_bp(v_bp), .v_act(v_act), .v_fp(v_fp),
        .pattern(pattern), .pattern_val(pattern_val),
        .vid(vid), .frame_cnt_o(frame_cnt_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int h_sync, h_bp, h_act, h_fp, v_sync, v_bp, v_act, v_fp, pat, pval;
    } cfg_t;

    typedef struct {
        cfg_t c;
        int   cycles, vs_clks, lines, pixels;
    } vec_t;

    int        checks = 0;
    int        errors = 0;
    logic [7:0] exp_q[$];

    logic      hs_at[512], vs_at[512], de_at[512], busy_at[512];
    logic [7:0] do_at[512];
    int        fc_at[512];
    int        budget_used, de_n, hs_rise, ovl;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pix(input cfg_t c, input int x, input int y);
        case (c.pat)
            0:       return 8'(x);
            1:       return 8'(y);
            2:       return ((((x >> 1) ^ (y >> 1)) & 1) != 0) ? 8'hFF : 8'h00;
            default: return 8'(c.pval);
        endcase
    endfunction

    task automatic push_frame(input cfg_t c);
        for (int y = 0; y < c.v_act; y++)
            for (int x = 0; x < c.h_act; x++)
                exp_q.push_back(pix(c, x, y));
    endtask

    task automatic apply(input cfg_t c);
        h_sync = 16'(c.h_sync); h_bp = 16'(c.h_bp); h_act = 16'(c.h_act); h_fp = 16'(c.h_fp);
        v_sync = 16'(c.v_sync); v_bp = 16'(c.v_bp); v_act = 16'(c.v_act); v_fp = 16'(c.v_fp);
        pattern = 2'(c.pat); pattern_val = 8'(c.pval);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        @(negedge clk);
        chk("rst_outputs", int'({vid.do_o, vid.de_o, vid.hs_o, vid.vs_o, busy_o}), 0);
        chk("rst_frame_cnt", int'(frame_cnt_o), 0);
        rst = 1'b0;
        exp_q.delete();
    endtask

    function automatic int first_fc(input int v);
        for (int k = 0; k < budget_used; k++)
            if (fc_at[k] == v) return k;
        return -1;
    endfunction

    function automatic int vs_count();
        int n = 0;
        for (int k = 0; k < budget_used; k++)
            if (vs_at[k]) n++;
        return n;
    endfunction

    // k counts negedges after the first edge that samples en=1.
    task automatic run(input cfg_t c1, input cfg_t c2, input int sw_k, input int drop1,
                       input int rise, input int drop2, input int budget);
        logic       hs_prev = 1'b0;
        logic [7:0] e;
        de_n = 0; hs_rise = 0; ovl = 0; budget_used = budget;
        apply(c1);
        en = 1'b1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            hs_at[k] = vid.hs_o; vs_at[k] = vid.vs_o; de_at[k] = vid.de_o;
            do_at[k] = vid.do_o; busy_at[k] = busy_o; fc_at[k] = int'(frame_cnt_o);
            if (vid.hs_o && !hs_prev) hs_rise++;
            hs_prev = vid.hs_o;
            if (vid.de_o && vid.hs_o) ovl++;
            if (vid.de_o) begin
                de_n++;
                if (exp_q.size() == 0) begin
                    chk("pix_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pixel", int'(vid.do_o), int'(e));
                end
            end
            if (k == sw_k)  apply(c2);
            if (k == drop1) en = 1'b0;
            if (k == rise)  en = 1'b1;
            if (k == drop2) en = 1'b0;
        end
    endtask

    vec_t vecs[4];
    cfg_t c0, csh;

    initial begin
        rst = 1'b0; en = 1'b0;
        c0 = '{4, 2, 8, 2, 1, 1, 3, 1, 0, 0};
        vecs[0] = '{c0, 96, 16, 6, 24};
        vecs[1] = '{'{4, 0, 8, 0, 1, 0, 4, 0, 2, 0}, 60, 12, 5, 32};
        vecs[2] = '{'{5, 1, 3, 2, 2, 1, 5, 1, 1, 0}, 99, 22, 9, 15};
        vecs[3] = '{'{4, 0, 1, 0, 1, 0, 1, 0, 3, 8'h5A}, 10, 5, 2, 1};
        apply(c0);

        // Single frame per configuration: en drops right after start, frame must complete.
        for (int i = 0; i < 4; i++) begin
            do_reset();
            push_frame(vecs[i].c);
            run(vecs[i].c, vecs[i].c, -1, 0, -1, -1, vecs[i].cycles + 12);
            chk("frame_len", first_fc(1), vecs[i].cycles);
            chk("first_hs_k0", int'(hs_at[0]), 0);
            chk("first_hs_k1", int'(hs_at[1]), 1);
            chk("vs_first", int'(vs_at[1]), 1);
            chk("vs_last", int'(vs_at[vecs[i].vs_clks]), 1);
            chk("vs_after", int'(vs_at[vecs[i].vs_clks + 1]), 0);
            chk("vs_total", vs_count(), vecs[i].vs_clks);
            chk("hs_rises", hs_rise, vecs[i].lines);
            chk("de_count", de_n, vecs[i].pixels);
            chk("queue_empty", exp_q.size(), 0);
            chk("busy_end", int'(busy_at[budget_used - 1]), 0);
            chk("idle_outputs", int'({do_at[budget_used - 1], de_at[budget_used - 1],
                                      hs_at[budget_used - 1], vs_at[budget_used - 1]}), 0);
            chk("hs_de_overlap", ovl, 0);
        end

        // en drops, returns before frame end, then drops during frame 2.
        do_reset();
        push_frame(c0);
        push_frame(c0);
        run(c0, c0, -1, 0, 40, 100, 205);
        chk("cont_fc1", first_fc(1), 96);
        chk("cont_fc2", first_fc(2), 192);
        chk("cont_busy96", int'(busy_at[96]), 1);
        chk("cont_hs97", int'(hs_at[97]), 1);
        chk("cont_vs97", int'(vs_at[97]), 1);
        chk("cont_de", de_n, 48);
        chk("cont_q", exp_q.size(), 0);
        chk("cont_busy_end", int'(busy_at[204]), 0);

        // Mid-frame change of h_act and pattern only takes effect in the next frame.
        do_reset();
        csh = c0;
        csh.h_act = 4; csh.pat = 3; csh.pval = 8'h5A;
        push_frame(c0);
        push_frame(csh);
        run(c0, csh, 10, -1, -1, 100, 180);
        chk("shadow_fc1", first_fc(1), 96);
        chk("shadow_fc2", first_fc(2), 168);
        chk("shadow_de", de_n, 36);
        chk("shadow_q", exp_q.size(), 0);
        apply(c0);

        // Reset during an active burst of frame 2, then restart from counter origin.
        do_reset();
        en = 1'b1;
        for (int k = 0; k <= 137; k++) @(negedge clk);
        chk("rst_mid_de", int'(vid.de_o), 1);
        chk("rst_mid_fc", int'(frame_cnt_o), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_outputs", int'({vid.do_o, vid.de_o, vid.hs_o, vid.vs_o, busy_o}), 0);
        chk("rst_mid_fcnt", int'(frame_cnt_o), 0);
        rst = 1'b0;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            hs_at[k] = vid.hs_o; vs_at[k] = vid.vs_o; de_at[k] = vid.de_o;
            do_at[k] = vid.do_o; busy_at[k] = busy_o;
            if (k == 1) en = 1'b0;
        end
        chk("restart_hs0", int'(hs_at[0]), 0);
        chk("restart_busy0", int'(busy_at[0]), 1);
        chk("restart_hs1", int'(hs_at[1]), 1);
        chk("restart_vs1", int'(vs_at[1]), 1);
        chk("restart_de38", int'(de_at[38]), 0);
        chk("restart_de39", int'(de_at[39]), 1);
        chk("restart_do40", int'(do_at[40]), 1);
        for (int k = 0; k < 100 && busy_o; k++) @(negedge clk);
        chk("restart_idle", int'(busy_o), 0);
        chk("restart_fc", int'(frame_cnt_o), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
